// File: rtl/commit_trace_tx.sv
// commit_trace_tx: collects up to three trace records per cycle (lane 0, lane 1, trap)
// into a FIFO and presents the head record to a downstream checker through a
// valid/ready handshake. A cycle's records are enqueued all together or dropped all
// together. Drops set a sticky overflow flag and bump a saturating counter.
module commit_trace_tx #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 cm_valid,
    input  logic [127:0]               cm_pc,
    input  logic [63:0]                cm_insn,
    input  logic [1:0]                 cm_wen,
    input  logic [9:0]                 cm_waddr,
    input  logic [127:0]               cm_wdata,
    input  logic                       trap_valid,
    input  logic [63:0]                trap_cause,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_kind,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_insn,
    output logic                       out_wen,
    output logic [4:0]                 out_waddr,
    output logic [63:0]                out_wdata,
    output logic                       space_ok,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    typedef struct packed {
        logic        kind;
        logic [63:0] pc;
        logic [31:0] insn;
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rec_t          cand [3];
    logic [2:0]    cand_v;
    rec_t          pack [3];
    logic [1:0]    n;
    logic          deq;
    logic [AW+1:0] free;
    logic          accept;
    logic [CNT_W+1:0] cnt_sum;
    rec_t          head;

    // Build the three candidate records and squeeze out invalid ones in order.
    always_comb begin
        cand[0] = '{kind: 1'b0, pc: cm_pc[63:0], insn: cm_insn[31:0], wen: cm_wen[0],
                    waddr: cm_waddr[4:0], wdata: cm_wdata[63:0]};
        cand[1] = '{kind: 1'b0, pc: cm_pc[127:64], insn: cm_insn[63:32], wen: cm_wen[1],
                    waddr: cm_waddr[9:5], wdata: cm_wdata[127:64]};
        cand[2] = '{kind: 1'b1, pc: '0, insn: '0, wen: 1'b0, waddr: '0, wdata: trap_cause};
        cand_v  = {trap_valid, cm_valid};
        for (int unsigned i = 0; i < 3; i++) pack[i] = '0;
        n = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (cand_v[i]) begin
                pack[n] = cand[i];
                n       = n + 2'd1;
            end
        end
    end

    // Next-state: all-or-nothing enqueue against space that counts this cycle's dequeue.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        deq      = (occ_q != '0) && out_ready;
        free     = DEPTH_W - {1'b0, occ_q} + (AW+2)'(deq);
        accept   = (AW+2)'(n) <= free;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + AW'(deq);
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        cnt_sum  = {2'b00, cnt_q} + (CNT_W+2)'(n);
        if (accept) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (2'(k) < n) mem_d[wr_ptr_q + AW'(k)] = pack[k];
            end
            wr_ptr_d = wr_ptr_q + AW'(n);
            occ_d    = occ_q + (AW+1)'(n) - (AW+1)'(deq);
        end else begin
            occ_d = occ_q - (AW+1)'(deq);
            ovf_d = 1'b1;
            cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Record storage; contents are only meaningful below occupancy, so no reset.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    // Head record straight from storage, forced to zero while empty.
    always_comb begin
        head       = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
        out_valid  = (occ_q != '0);
        out_kind   = head.kind;
        out_pc     = head.pc;
        out_insn   = head.insn;
        out_wen    = head.wen;
        out_waddr  = head.waddr;
        out_wdata  = head.wdata;
        occupancy  = occ_q;
        overflow   = ovf_q;
        drop_count = cnt_q;
        space_ok   = (DEPTH_W - {1'b0, occ_q}) >= (AW+2)'(3);
    end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Randomized bench for commit_trace_tx with a queue-based reference model.
module tb_commit_trace_tx;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   cm_valid;
    logic [127:0] cm_pc;
    logic [63:0]  cm_insn;
    logic [1:0]   cm_wen;
    logic [9:0]   cm_waddr;
    logic [127:0] cm_wdata;
    logic         trap_valid;
    logic [63:0]  trap_cause;
    logic         out_valid;
    logic         out_ready;
    logic         out_kind;
    logic [63:0]  out_pc;
    logic [31:0]  out_insn;
    logic         out_wen;
    logic [4:0]   out_waddr;
    logic [63:0]  out_wdata;
    logic         space_ok;
    logic [3:0]   occupancy;
    logic         overflow;
    logic [CNT_W-1:0] drop_count;

    commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .cm_valid(cm_valid), .cm_pc(cm_pc),
        .cm_insn(cm_insn), .cm_wen(cm_wen), .cm_waddr(cm_waddr), .cm_wdata(cm_wdata),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_pc(out_pc), .out_insn(out_insn),
        .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
        .space_ok(space_ok), .occupancy(occupancy), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef logic [166:0] rec_t;
    rec_t q[$];
    bit   m_ovf;
    int   m_cnt;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        cm_pc      = {$urandom, $urandom, $urandom, $urandom};
        cm_insn    = {$urandom, $urandom};
        cm_wen     = 2'($urandom);
        cm_waddr   = 10'($urandom);
        cm_wdata   = {$urandom, $urandom, $urandom, $urandom};
        trap_cause = {$urandom, $urandom};
    endtask

    // Apply one cycle of stimulus, advance the model, then compare after the edge.
    task automatic step(input logic [1:0] cv, input logic tv, input logic rdy, input logic rst);
        rec_t in_recs[$];
        int   free;
        bit   deq;
        rec_t exp_head;
        @(negedge clock);
        cm_valid = cv; trap_valid = tv; out_ready = rdy; reset = rst;
        if (!rst) begin
            q.delete(); m_ovf = 0; m_cnt = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (cv[i]) in_recs.push_back({1'b0, cm_pc[64*i +: 64], cm_insn[32*i +: 32],
                                              cm_wen[i], cm_waddr[5*i +: 5], cm_wdata[64*i +: 64]});
            if (tv) in_recs.push_back({1'b1, 64'd0, 32'd0, 1'b0, 5'd0, trap_cause});
            deq  = (q.size() != 0) && rdy;
            free = DEPTH - q.size() + (deq ? 1 : 0);
            if (deq) void'(q.pop_front());
            if (in_recs.size() <= free) begin
                foreach (in_recs[k]) q.push_back(in_recs[k]);
            end else begin
                m_ovf = 1;
                m_cnt = m_cnt + in_recs.size();
                if (m_cnt > CMAX) m_cnt = CMAX;
            end
        end
        @(posedge clock);
        #1;
        exp_head = (q.size() != 0) ? q[0] : '0;
        check("out_valid", out_valid, q.size() != 0);
        check("occupancy", occupancy, q.size());
        check("space_ok", space_ok, (DEPTH - q.size()) >= 3);
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_cnt);
        check("head", {out_kind, out_pc, out_insn, out_wen, out_waddr, out_wdata}, exp_head);
    endtask

    initial begin
        reset = 1'b0; cm_valid = '0; trap_valid = 1'b0; out_ready = 1'b0;
        rand_payload();

        // reset state
        step(2'b11, 1'b1, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);

        // two lanes plus trap in one cycle, drained in order
        rand_payload();
        step(2'b11, 1'b1, 1'b0, 1'b1);
        check("three_occ", occupancy, 4'd3);
        check("first_kind", out_kind, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        check("second_kind", out_kind, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        check("trap_kind", out_kind, 1'b1);
        step(2'b00, 1'b0, 1'b1, 1'b1);

        // lane 1 only lands in slot 0
        rand_payload();
        cm_pc[127:64] = 64'h80000004;
        step(2'b10, 1'b0, 1'b0, 1'b1);
        check("lane1_pc", out_pc, 64'h80000004);
        step(2'b00, 1'b0, 1'b1, 1'b1);

        // fill to 7, dual commit dropped whole
        for (int i = 0; i < 7; i++) begin
            rand_payload();
            step(2'b01, 1'b0, 1'b0, 1'b1);
        end
        rand_payload();
        step(2'b11, 1'b0, 1'b0, 1'b1);
        check("drop_occ", occupancy, 4'd7);
        check("drop_cnt2", drop_count, 4'd2);

        // full FIFO with simultaneous dequeue
        rand_payload();
        step(2'b01, 1'b0, 1'b0, 1'b1);
        check("full_occ", occupancy, 4'd8);
        rand_payload();
        step(2'b01, 1'b0, 1'b1, 1'b1);
        check("full_swap", occupancy, 4'd8);
        rand_payload();
        step(2'b11, 1'b0, 1'b1, 1'b1);
        check("full_drop", occupancy, 4'd7);

        // 20 single commits with random backpressure across pointer wrap
        step(2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            rand_payload();
            step(2'b01 << (i % 2), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        end
        for (int i = 0; i < 12; i++) step(2'b00, 1'b0, 1'($urandom_range(0, 1)), 1'b1);

        // random traffic, alternating light and heavy backpressure
        for (int i = 0; i < 2000; i++) begin
            rand_payload();
            step(2'($urandom), ($urandom_range(0, 3) == 0),
                 ((i / 100) % 2 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 499) != 0));
        end

        // occupancy 5 with overflow set, then reset clears everything
        step(2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rand_payload();
            step(2'b01, 1'b0, 1'b0, 1'b1);
        end
        rand_payload();
        step(2'b11, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b1, 1'b1);
        check("pre_occ5", occupancy, 4'd5);
        check("pre_ovf", overflow, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        check("rst_occ", occupancy, 4'd0);
        check("rst_data", {out_kind, out_pc, out_insn, out_wen, out_waddr, out_wdata}, 192'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
